// File: rtl/fru_patch_ctrl_unit.sv
// Field-repair patch controller: turns a 1-bit PLA trigger into a timed, masked override
// of a control bus, with programmable delay, duration, hold-off and arming mode.
module fru_patch_ctrl_unit #(
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned DELAY_W    = 8,
    parameter int unsigned DUR_W      = 8,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  PlaSelect,
    input  logic [CTRL_WIDTH-1:0] CtrlIn,
    input  logic [CTRL_WIDTH-1:0] RegPatchValue,
    input  logic [CTRL_WIDTH-1:0] RegPatchMask,
    input  logic [1:0]            RegMode,
    input  logic [DELAY_W-1:0]    RegDelay,
    input  logic [DUR_W-1:0]      RegDuration,
    input  logic [DELAY_W-1:0]    RegHoldoff,
    output logic [CTRL_WIDTH-1:0] CtrlOut,
    output logic                  PatchActive,
    output logic [CNT_W-1:0]      PatchCount
);

    localparam int unsigned CntW = (DELAY_W > DUR_W) ? DELAY_W : DUR_W;
    localparam logic [CntW-1:0]  CntOne = 1;
    localparam logic [CNT_W-1:0] PcOne  = 1;

    localparam logic [1:0] ModeOff     = 2'd0;
    localparam logic [1:0] ModeOneShot = 2'd1;
    localparam logic [1:0] ModeRetrig  = 2'd2;
    localparam logic [1:0] ModeLevel   = 2'd3;

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StActive,
        StHoldoff,
        StDone
    } state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic             pla_select_q;
    logic [CNT_W-1:0] patch_count_q;
    logic [CNT_W-1:0] patch_count_d;

    logic             trig;
    logic             enter_active;
    logic [CntW-1:0]  delay_ext;
    logic [CntW-1:0]  holdoff_ext;
    logic [CntW-1:0]  dur_load;

    assign delay_ext   = CntW'(RegDelay);
    assign holdoff_ext = CntW'(RegHoldoff);
    // A zero duration still yields one active cycle.
    assign dur_load    = (RegDuration == '0) ? '0 : (CntW'(RegDuration) - CntOne);

    always_comb begin
        trig = 1'b0;
        case (RegMode)
            ModeOneShot, ModeRetrig: trig = PlaSelect & ~pla_select_q;
            ModeLevel:               trig = PlaSelect;
            default:                 trig = 1'b0;
        endcase
    end

    always_comb begin
        enter_active = 1'b0;
        if (RegMode != ModeOff) begin
            if (state_q == StIdle && trig && RegDelay == '0) begin
                enter_active = 1'b1;
            end else if (state_q == StDelay && cnt_q == '0) begin
                enter_active = 1'b1;
            end
        end
    end

    always_comb begin
        patch_count_d = patch_count_q;
        if (enter_active && patch_count_q != '1) begin
            patch_count_d = patch_count_q + PcOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            pla_select_q  <= 1'b0;
            patch_count_q <= '0;
        end else begin
            pla_select_q  <= PlaSelect;
            patch_count_q <= patch_count_d;
            // Disabling wins over every other transition; the counter is left as is.
            if (RegMode == ModeOff) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (trig) begin
                            if (RegDelay != '0) begin
                                state_q <= StDelay;
                                cnt_q   <= delay_ext - CntOne;
                            end else begin
                                state_q <= StActive;
                                cnt_q   <= dur_load;
                            end
                        end
                    end
                    StDelay: begin
                        if (cnt_q == '0) begin
                            state_q <= StActive;
                            cnt_q   <= dur_load;
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                    StActive: begin
                        if (RegMode == ModeLevel) begin
                            if (!PlaSelect) begin
                                state_q <= StIdle;
                            end
                        end else if (cnt_q == '0) begin
                            if (RegMode == ModeOneShot) begin
                                state_q <= StDone;
                            end else if (RegHoldoff == '0) begin
                                state_q <= StIdle;
                            end else begin
                                state_q <= StHoldoff;
                                cnt_q   <= holdoff_ext - CntOne;
                            end
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                    StHoldoff: begin
                        if (cnt_q == '0) begin
                            state_q <= StIdle;
                        end else begin
                            cnt_q <= cnt_q - CntOne;
                        end
                    end
                    StDone: begin
                        state_q <= StDone;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign PatchActive = (state_q == StActive);
    assign PatchCount  = patch_count_q;
    assign CtrlOut     = PatchActive ? ((CtrlIn & ~RegPatchMask) | (RegPatchValue & RegPatchMask))
                                     : CtrlIn;

endmodule
